// File: rtl/gate_sweep_pkg.sv
// Shared types and sizes for the two-input gate sweep sequencer.
// The state encoding values are fixed so that debug probes read the same everywhere.
package gate_sweep_pkg;

    localparam int NUM_VECTORS = 4;
    localparam int IDX_W       = 2;
    localparam int CNT_W       = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Returns tt with bit idx replaced by the sampled gate output.
    function automatic logic [NUM_VECTORS-1:0] tt_set_bit(
        input logic [NUM_VECTORS-1:0] tt,
        input logic [IDX_W-1:0]       idx,
        input logic                   y
    );
        logic [NUM_VECTORS-1:0] res;
        res      = tt;
        res[idx] = y;
        return res;
    endfunction

endpackage

// File: rtl/gate_sweep_ctrl_if.sv
// Host-side handshake of the gate sweep sequencer: request/abort in, status and truth table out.
interface gate_sweep_ctrl_if;
    import gate_sweep_pkg::*;

    logic                   start;
    logic                   abort;
    logic                   busy;
    logic                   done;
    logic [NUM_VECTORS-1:0] tt;
    logic                   pass;

    modport master (output start, output abort, input busy, input done, input tt, input pass);
    modport slave  (input start, input abort, output busy, output done, output tt, output pass);

endinterface

// File: rtl/gate_sweep_ctrl_settle_timer.sv
// Settle counter: cleared while clr is high, counts while en is high,
// hit flags the last settle cycle (count == SETTLE_CYCLES-1).
module settle_timer
    import gate_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    logic [CNT_W-1:0] count_r;

    // Counter register with clear taking priority over count enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (en) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign hit = (count_r == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sweeps a two-input gate through 00,01,10,11, samples y after a settle time
// and compares the captured truth table against EXPECT_TT.
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int                     SETTLE_CYCLES = 2,
    parameter logic [NUM_VECTORS-1:0] EXPECT_TT     = 4'b1000
) (
    input  logic               clk,
    input  logic               rst,
    gate_sweep_ctrl_if.slave   host,
    output logic               a,
    output logic               b,
    input  logic               y
);

    state_e                 state_r, state_next_s;
    logic [IDX_W-1:0]       idx_r, idx_next_s;
    logic [1:0]             ab_r, ab_next_s;
    logic [NUM_VECTORS-1:0] tt_r, tt_next_s;
    logic                   pass_r, pass_next_s;
    logic                   busy_r, busy_next_s;
    logic                   done_r, done_next_s;
    logic                   hit_s;

    settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk (clk),
        .rst (rst),
        .clr (state_r != SETTLE),
        .en  (state_r == SETTLE),
        .hit (hit_s)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= {IDX_W{1'b0}};
            ab_r    <= 2'b00;
            tt_r    <= {NUM_VECTORS{1'b0}};
            pass_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
            ab_r    <= ab_next_s;
            tt_r    <= tt_next_s;
            pass_r  <= pass_next_s;
            busy_r  <= busy_next_s;
            done_r  <= done_next_s;
        end
    end

    // Next-state and next register values; abort is applied last so it overrides everything.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        ab_next_s    = ab_r;
        tt_next_s    = tt_r;
        pass_next_s  = pass_r;
        busy_next_s  = busy_r;
        done_next_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (host.start && !host.abort) begin
                    state_next_s = SETTLE;
                    idx_next_s   = {IDX_W{1'b0}};
                    ab_next_s    = 2'b00;
                    tt_next_s    = {NUM_VECTORS{1'b0}};
                    pass_next_s  = 1'b0;
                    busy_next_s  = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SETTLE: begin
                if (hit_s) begin
                    state_next_s = SAMPLE;
                end else begin
                    state_next_s = SETTLE;
                end
            end
            SAMPLE: begin
                tt_next_s = tt_set_bit(tt_r, idx_r, y);
                // pass uses the completed table so it is valid together with done.
                if (idx_r == IDX_W'(NUM_VECTORS - 1)) begin
                    state_next_s = DONE;
                    done_next_s  = 1'b1;
                    busy_next_s  = 1'b0;
                    pass_next_s  = (tt_next_s == EXPECT_TT);
                end else begin
                    state_next_s = SETTLE;
                    idx_next_s   = idx_r + IDX_W'(1);
                    ab_next_s    = idx_r + IDX_W'(1);
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase

        if (host.abort && (state_r != IDLE)) begin
            state_next_s = IDLE;
            idx_next_s   = {IDX_W{1'b0}};
            ab_next_s    = 2'b00;
            tt_next_s    = tt_r;
            pass_next_s  = 1'b0;
            busy_next_s  = 1'b0;
            done_next_s  = 1'b0;
        end else begin
            done_next_s  = done_next_s;
        end
    end

    assign a         = ab_r[1];
    assign b         = ab_r[0];
    assign host.busy = busy_r;
    assign host.done = done_r;
    assign host.tt   = tt_r;
    assign host.pass = pass_r;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl: one instance with default settle time,
// one with SETTLE_CYCLES=1, each driving a behavioural gate whose function is selectable.
module tb_gate_sweep_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   mode  = 0;   // 0: AND, 1: XOR, 2: NAND
    logic a0, b0, y0, a1, b1, y1;

    gate_sweep_ctrl_if h0 ();
    gate_sweep_ctrl_if h1 ();

    gate_sweep_ctrl dut0 (
        .clk  (clk),
        .rst  (rst),
        .host (h0),
        .a    (a0),
        .b    (b0),
        .y    (y0)
    );

    gate_sweep_ctrl #(.SETTLE_CYCLES(1), .EXPECT_TT(4'b1000)) dut1 (
        .clk  (clk),
        .rst  (rst),
        .host (h1),
        .a    (a1),
        .b    (b1),
        .y    (y1)
    );

    always #5 clk = ~clk;

    function automatic logic gate_fn(input int m, input logic ga, input logic gb);
        case (m)
            1:       return ga ^ gb;
            2:       return ~(ga & gb);
            default: return ga & gb;
        endcase
    endfunction

    assign y0 = gate_fn(mode, a0, b0);
    assign y1 = gate_fn(mode, a1, b1);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full default-parameter sweep, checked every cycle; optional stray start at cycle extra_start.
    task automatic sweep0(input logic [3:0] exp_tt, input logic exp_pass, input int extra_start);
        int ndone;
        int vec;
        ndone = 0;
        h0.start = 1'b1;
        tick();
        h0.start = 1'b0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            if (cyc == extra_start) h0.start = 1'b1;
            vec = (cyc <= 12) ? (cyc - 1) / 3 : 3;
            chk($sformatf("ab_c%0d", cyc), {30'd0, a0, b0}, vec);
            chk($sformatf("busy_c%0d", cyc), {31'd0, h0.busy}, (cyc <= 12) ? 1 : 0);
            chk($sformatf("done_c%0d", cyc), {31'd0, h0.done}, (cyc == 13) ? 1 : 0);
            if (h0.done === 1'b1) ndone++;
            if (cyc >= 13) begin
                chk($sformatf("tt_c%0d", cyc), {28'd0, h0.tt}, {28'd0, exp_tt});
                chk($sformatf("pass_c%0d", cyc), {31'd0, h0.pass}, {31'd0, exp_pass});
            end
            tick();
            h0.start = 1'b0;
        end
        chk("done_count", ndone, 1);
    endtask

    // Sweep on the SETTLE_CYCLES=1 instance; returns the cycle at which done was seen.
    task automatic sweep1(output int n);
        h1.start = 1'b1;
        tick();
        h1.start = 1'b0;
        n = 1;
        while (h1.done !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        h0.start = 1'b0; h0.abort = 1'b0;
        h1.start = 1'b0; h1.abort = 1'b0;
        tick();
        tick();
        chk("rst_ab",   {30'd0, a0, b0}, 0);
        chk("rst_busy", {31'd0, h0.busy}, 0);
        chk("rst_done", {31'd0, h0.done}, 0);
        chk("rst_tt",   {28'd0, h0.tt}, 0);
        chk("rst_pass", {31'd0, h0.pass}, 0);
        rst = 1'b0;
        tick();

        // AND gate, default settle time
        mode = 0;
        sweep0(4'b1000, 1'b1, 0);

        // XOR gate: table differs from expectation
        mode = 1;
        sweep0(4'b0110, 1'b0, 0);

        // SETTLE_CYCLES=1 instance, back-to-back sweeps
        mode = 0;
        sweep1(n);
        chk("s1_done_cyc", n, 9);
        chk("s1_tt",   {28'd0, h1.tt}, 32'h8);
        chk("s1_pass", {31'd0, h1.pass}, 1);
        tick();
        chk("s1_done_low", {31'd0, h1.done}, 0);
        sweep1(n);
        chk("s1_b2b_done_cyc", n, 9);
        chk("s1_b2b_tt", {28'd0, h1.tt}, 32'h8);
        tick();

        // Abort during vector-1 settle, NAND gate so vector 0 samples a 1
        mode = 2;
        h0.start = 1'b1;
        tick();
        h0.start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        chk("ab_pre_busy", {31'd0, h0.busy}, 1);
        chk("ab_pre_vec",  {30'd0, a0, b0}, 1);
        h0.abort = 1'b1;
        tick();
        h0.abort = 1'b0;
        chk("abort_busy", {31'd0, h0.busy}, 0);
        chk("abort_ab",   {30'd0, a0, b0}, 0);
        chk("abort_pass", {31'd0, h0.pass}, 0);
        chk("abort_tt",   {28'd0, h0.tt}, 32'h1);
        for (int c = 0; c < 14; c++) begin
            chk($sformatf("abort_nodone_%0d", c), {31'd0, h0.done}, 0);
            tick();
        end
        chk("abort_idle_busy", {31'd0, h0.busy}, 0);

        // Reset at cycle 7 mid-sweep
        h0.start = 1'b1;
        tick();
        h0.start = 1'b0;
        for (int c = 1; c < 7; c++) tick();
        chk("rs_pre_tt", {28'd0, h0.tt}, 32'h3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rs_ab",   {30'd0, a0, b0}, 0);
        chk("rs_busy", {31'd0, h0.busy}, 0);
        chk("rs_done", {31'd0, h0.done}, 0);
        chk("rs_tt",   {28'd0, h0.tt}, 0);
        chk("rs_pass", {31'd0, h0.pass}, 0);
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("rs_nodone_%0d", c), {31'd0, h0.done}, 0);
            tick();
        end
        mode = 0;
        sweep0(4'b1000, 1'b1, 0);

        // Second start at cycle 4 is ignored
        sweep0(4'b1000, 1'b1, 4);

        // start and abort together in IDLE
        h0.start = 1'b1;
        h0.abort = 1'b1;
        tick();
        h0.start = 1'b0;
        h0.abort = 1'b0;
        chk("sa_busy", {31'd0, h0.busy}, 0);
        tick();
        chk("sa_busy2", {31'd0, h0.busy}, 0);
        chk("sa_done", {31'd0, h0.done}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gate_sweep_ctrl.md
# gate_sweep_ctrl

Sequencer for the two-input combinational gate (`hello_world`: inputs `a`, `b`, output `y`). On a start pulse it drives the gate through all four input vectors in order 00, 01, 10, 11. It waits a programmable settle time before sampling `y` for each vector, then assembles a 4-bit truth table and compares it against an expected value. It sits between a host/self-test master and the gate instance, replacing the hand-written stimulus sequence with synthesizable hardware.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles the gate inputs are held before `y` is sampled; legal range 1..255.
- `EXPECT_TT`, default 4'b1000: expected truth table, bit index = {a,b}; the default is an AND gate.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- `abort`  in  1  terminate the sweep; return to IDLE next cycle with no `done`.
- `a`  out  1  gate input a, registered.
- `b`  out  1  gate input b, registered.
- `y`  in  1  gate output, sampled in SAMPLE.
- `busy`  out  1  high from the cycle after start is accepted until DONE.
- `done`  out  1  one-cycle pulse in DONE.
- `tt`  out  4  captured truth table; bit[{a,b}] = sampled `y`.
- `pass`  out  1  (tt == EXPECT_TT); updated in DONE, held until the next accepted start.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - `start`=1 and `abort`=0 → SETTLE.
  - Same edge: idx←0, {a,b}←00, tt←0, pass←0, settle count←0, busy←1.
- SETTLE:
  - Count increments each cycle.
  - On the cycle where count == SETTLE_CYCLES-1 → SAMPLE.
- SAMPLE (exactly one cycle): tt[idx]←y.
  - idx==3 → DONE.
  - Otherwise idx←idx+1, {a,b}←idx+1, count←0 → SETTLE.
- DONE (one cycle):
  - done=1, busy←0, pass←(tt==EXPECT_TT) using the completed tt.
  - → IDLE.
  - {a,b} keep 11.
- `abort`:
  - In any non-IDLE state: next state IDLE, busy←0, done stays 0.
  - tt holds partial contents; pass←0; {a,b}←00.
  - Overrides every other transition, including SAMPLE→DONE.
- `start` while busy or in DONE is ignored, not queued.
- `start` and `abort` together in IDLE: abort wins, stay IDLE.
- idx is 2 bits and never wraps; the sweep ends at idx==3.

## Timing
- Reset values: a=0, b=0, busy=0, done=0, tt=4'b0000, pass=0, state IDLE, idx=0, count=0.
- `rst` mid-sweep: all of the above on the next edge; no done pulse.
- Cycle 0 is the edge that samples `start`:
  - Cycle 1: {a,b}=00, busy=1.
  - Vector k (0..3) is driven for SETTLE_CYCLES+1 cycles, then sampled in its SAMPLE cycle at cycle (k+1)(SETTLE_CYCLES+1).
  - `done` asserts at cycle 4·(SETTLE_CYCLES+1)+1. Default: cycle 13.
- `pass` and `tt` are valid in the `done` cycle and all following cycles until the next accepted start.
- The earliest next `start` is accepted the cycle after `done` (back-to-back sweeps).

## Structure
- Package `gate_sweep_pkg`:
  - state encoding constants (IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, DONE=2'd3)
  - NUM_VECTORS=4, IDX_W=2, CNT_W=8
- Sub-module `settle_timer`: CNT_W-bit counter with `clr`/`en` inputs and a `hit` output when count == SETTLE_CYCLES-1.
- FSM, idx register, tt/pass registers and output regs stay in `gate_sweep_ctrl`.
- `hello_world` is instantiated by the enclosing wrapper/bench, not inside this block.

## Test plan
- AND gate, default params, start at cycle 0:
  - {a,b} sequence 00,01,10,11, each held 3 cycles.
  - done at cycle 13, tt=4'b1000, pass=1.
- Bench model replaced by XOR:
  - tt=4'b0110, pass=0 with done.
  - busy falls in the same cycle that done rises.
- SETTLE_CYCLES=1:
  - done at cycle 9, tt correct.
  - Second start the cycle after done is accepted; the second done arrives 9 cycles later.
- Abort asserted at cycle 5 (SETTLE of vector 1):
  - Next cycle state IDLE, busy=0, {a,b}=00, pass=0, no done pulse.
  - tt[0] holds the vector-0 sample.
- `rst` asserted at cycle 7 mid-sweep:
  - Next cycle all outputs at reset values, done never pulses.
  - A start after reset release gives a full sweep with done 13 cycles later.
- start pulsed at cycles 0 and 4:
  - The cycle-4 start is ignored.
  - Exactly one done, at cycle 13.
- start+abort together in IDLE: busy stays 0.
